// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared constants and types for branch resolution
package branch_resolve_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - stage-2 instruction, comparator, redirect and counter signals
interface branch_resolve_if
   import branch_resolve_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             stall;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic [2:0]       funct3;
   logic             eq;
   logic             lt;
   logic             cmp_signed;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1d;
   logic             redirect_valid;
   logic             redirect_ready;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush;
   logic             misalign_err;
   logic             clr_cnt;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output in_valid, stall, is_branch, is_jal, is_jalr, funct3, eq, lt,
             pc, imm, rs1d, redirect_ready, clr_cnt,
      input  in_ready, cmp_signed, redirect_valid, redirect_pc, flush,
             misalign_err, branch_cnt, taken_cnt
   );

   modport slave (
      input  in_valid, stall, is_branch, is_jal, is_jalr, funct3, eq, lt,
             pc, imm, rs1d, redirect_ready, clr_cnt,
      output in_ready, cmp_signed, redirect_valid, redirect_pc, flush,
             misalign_err, branch_cnt, taken_cnt
   );

endinterface

// File: rtl/branch_resolve_cond.sv
// rtl/branch_resolve_cond.sv - funct3/eq/lt decode into taken, legality and comparator signedness
module branch_cond
   import branch_resolve_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       eq,
   input  logic       lt,
   output logic       taken,
   output logic       legal,
   output logic       cmp_signed
);

   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      case (funct3)
         BEQ:        taken = eq;
         BNE:        taken = !eq;
         BLT, BLTU:  taken = lt;
         BGE, BGEU:  taken = !lt;
         default:    legal = 1'b0;
      endcase
   end

   assign cmp_signed = !((funct3 == BLTU) || (funct3 == BGEU));

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch/jump resolution, registered redirect with one-cycle flush, stats counters
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 32
)(
   input  logic            clk,
   input  logic            reset,
   branch_resolve_if.slave bus
);

   state_e           state, state_nxt;
   logic             first_q;
   logic             mis_q;
   logic [XLEN-1:0]  target_q;
   logic [CNT_W-1:0] branch_q, taken_q;

   logic             cond_taken, cond_legal;
   logic             accept, taken, go_pend, misalign;
   logic [XLEN-1:0]  sum, target;

   branch_cond u_cond (
      .funct3     (bus.funct3),
      .eq         (bus.eq),
      .lt         (bus.lt),
      .taken      (cond_taken),
      .legal      (cond_legal),
      .cmp_signed (bus.cmp_signed)
   );

   assign accept   = bus.in_valid && (state == IDLE) && !bus.stall;
   assign sum      = bus.is_jalr ? (bus.rs1d + bus.imm) : (bus.pc + bus.imm);
   assign target   = {sum[XLEN-1:1], sum[0] & !bus.is_jalr};
   assign taken    = bus.is_jal || bus.is_jalr || (bus.is_branch && cond_taken);
   // A misaligned target traps instead of redirecting, so it never enters PEND
   assign go_pend  = accept && taken && !target[1];
   assign misalign = accept && taken && target[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_pend) state_nxt = PEND;
         PEND:    if (bus.redirect_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready       = (state == IDLE);
      bus.redirect_valid = (state == PEND);
      bus.flush          = (state == PEND) && first_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_q  <= 1'b0;
         mis_q    <= 1'b0;
         target_q <= '0;
      end else begin
         first_q <= go_pend;
         mis_q   <= misalign;
         if (go_pend) target_q <= target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_q <= '0;
         taken_q  <= '0;
      end else if (bus.clr_cnt) begin
         branch_q <= '0;
         taken_q  <= '0;
      end else if (accept && bus.is_branch && cond_legal) begin
         branch_q <= branch_q + CNT_W'(1);
         if (cond_taken) taken_q <= taken_q + CNT_W'(1);
      end
   end

   assign bus.redirect_pc  = target_q;
   assign bus.misalign_err = mis_q;
   assign bus.branch_cnt   = branch_q;
   assign bus.taken_cnt    = taken_q;

endmodule
